// File: rtl/dds_multi_channel.sv
// rtl/dds_multi_channel.sv - N-channel phase-coherent DDS with shadowed per-channel settings
// Quarter-wave sine LUT, 3-stage pipeline (phase index, LUT/sign, scale/round), Q3.13 outputs.
module dds_multi_channel #(
  parameter int N_CH  = 4,
  parameter int ACC_W = 16,
  parameter int PH_W  = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [CH_W-1:0]      ch_sel,
  input  logic [ACC_W-1:0]     freq_word,
  input  logic [PH_W-1:0]      phase_word,
  input  logic [7:0]           amp_word,
  input  logic                 mode_word,
  input  logic                 commit,
  input  logic                 sync_phase,
  output logic [N_CH*16-1:0]   sample_out,
  output logic                 out_valid
);

  localparam int Q = 1 << (PH_W - 2);

  // Elaboration-time table: round(16383*sin(pi/2*k/Q)) via a Taylor series, no runtime math
  function automatic logic signed [15:0] lut_entry(input int k);
    real x, term, sum;
    x    = 3.14159265358979323846 / 2.0 * real'(k) / real'(Q);
    term = x;
    sum  = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return 16'($rtoi(16383.0 * sum + 0.5));
  endfunction

  logic [ACC_W-1:0]   r_sh_freq   [N_CH];
  logic [PH_W-1:0]    r_sh_phase  [N_CH];
  logic [7:0]         r_sh_amp    [N_CH];
  logic               r_sh_mode   [N_CH];
  logic [ACC_W-1:0]   r_act_freq  [N_CH];
  logic [PH_W-1:0]    r_act_phase [N_CH];
  logic [7:0]         r_act_amp   [N_CH];
  logic               r_act_mode  [N_CH];
  logic [ACC_W-1:0]   r_acc       [N_CH];
  logic [PH_W-1:0]    r_s1_p      [N_CH];
  logic [7:0]         r_s1_amp    [N_CH];
  logic signed [15:0] r_s2_sin    [N_CH];
  logic signed [7:0]  r_s2_amp    [N_CH];
  logic [N_CH*16-1:0] r_sample;
  logic [1:0]         r_fill;

  logic               w_ld   [N_CH];
  logic [PH_W-1:0]    w_p    [N_CH];
  logic [PH_W-2:0]    w_addr [N_CH];
  logic signed [15:0] w_sin  [N_CH];
  logic signed [23:0] w_prod [N_CH];
  logic signed [24:0] w_rnd  [N_CH];
  logic signed [24:0] w_sh   [N_CH];
  logic signed [15:0] w_out  [N_CH];
  logic signed [15:0] w_lut  [0:Q];

  for (genvar k = 0; k <= Q; k++) begin : g_lut
    assign w_lut[k] = lut_entry(k);
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_ld[i]   = load && (int'(ch_sel) == i);
      w_p[i]    = r_acc[i][ACC_W-1 -: PH_W] + r_act_phase[i]
                + (r_act_mode[i] ? PH_W'(Q) : PH_W'(0));
      // Odd quadrants read the table backwards, upper half-period is negated
      w_addr[i] = r_s1_p[i][PH_W-2] ? (PH_W-1)'(Q) - {1'b0, r_s1_p[i][PH_W-3:0]}
                                    : {1'b0, r_s1_p[i][PH_W-3:0]};
      w_sin[i]  = r_s1_p[i][PH_W-1] ? -w_lut[w_addr[i]] : w_lut[w_addr[i]];
      w_prod[i] = r_s2_sin[i] * r_s2_amp[i];
      w_rnd[i]  = $signed({w_prod[i][23], w_prod[i]}) + 25'sd32;
      w_sh[i]   = w_rnd[i] >>> 6;
      if (w_sh[i] > 25'sd32767) begin
        w_out[i] = 16'sh7FFF;
      end else if (w_sh[i] < -25'sd32768) begin
        w_out[i] = 16'sh8000;
      end else begin
        w_out[i] = w_sh[i][15:0];
      end
    end
  end

  // Settings and accumulators: load/commit are independent of en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_sh_freq[i]   <= '0;
        r_sh_phase[i]  <= '0;
        r_sh_amp[i]    <= '0;
        r_sh_mode[i]   <= 1'b0;
        r_act_freq[i]  <= '0;
        r_act_phase[i] <= '0;
        r_act_amp[i]   <= '0;
        r_act_mode[i]  <= 1'b0;
        r_acc[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_ld[i]) begin
          r_sh_freq[i]  <= freq_word;
          r_sh_phase[i] <= phase_word;
          r_sh_amp[i]   <= amp_word;
          r_sh_mode[i]  <= mode_word;
        end
        if (commit) begin
          r_act_freq[i]  <= w_ld[i] ? freq_word  : r_sh_freq[i];
          r_act_phase[i] <= w_ld[i] ? phase_word : r_sh_phase[i];
          r_act_amp[i]   <= w_ld[i] ? amp_word   : r_sh_amp[i];
          r_act_mode[i]  <= w_ld[i] ? mode_word  : r_sh_mode[i];
        end
        if (commit && sync_phase) begin
          r_acc[i] <= '0;
        end else if (en) begin
          r_acc[i] <= r_acc[i] + r_act_freq[i];
        end
      end
    end
  end

  // Amplitude travels with its phase index so a commit takes effect on a clean sample boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_s1_p[i]   <= '0;
        r_s1_amp[i] <= '0;
        r_s2_sin[i] <= '0;
        r_s2_amp[i] <= '0;
      end
      r_sample <= '0;
      r_fill   <= '0;
    end else if (en) begin
      for (int i = 0; i < N_CH; i++) begin
        r_s1_p[i]              <= w_p[i];
        r_s1_amp[i]            <= r_act_amp[i];
        r_s2_sin[i]            <= w_sin[i];
        r_s2_amp[i]            <= r_s1_amp[i];
        r_sample[16*i +: 16]   <= w_out[i];
      end
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  assign sample_out = r_sample;
  assign out_valid  = en && (r_fill == 2'd3);

endmodule
